// File: rtl/imem_responder.sv
// imem_responder: word-organised on-chip RAM answering single-outstanding
// valid/ready/rvalid requests after a fixed latency. It serves reads and
// byte-masked writes, flags out-of-range and misaligned accesses, and returns
// exactly one rvalid pulse per accepted request.
module imem_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              LATENCY     = 2,
  parameter string           INIT_FILE   = "",
  parameter logic [XLEN-1:0] FILL_WORD   = XLEN'(32'h0000_0013)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [XLEN-1:0]   i_addr,
  input  logic              i_rw,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN/8-1:0] i_wmask,
  output logic              o_ready,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_rvalid,
  output logic              o_err,
  output logic [15:0]       o_req_count
);

  localparam int            LANES    = XLEN / 8;
  localparam int            IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN:0] SPAN     = (XLEN + 1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0]    CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic accept;
  logic enter_respond;
  logic commit;

  // Latched request (captured on accept, held until the response)
  logic [XLEN-1:0]  req_addr_p0;
  logic             req_rw_p0;
  logic [XLEN-1:0]  req_wdata_p0;
  logic [LANES-1:0] req_wmask_p0;

  // Decode of whichever request is being answered
  logic [XLEN-1:0] src_addr;
  logic            src_rw;
  logic [XLEN:0]   offset;
  logic            in_range;
  logic            aligned;
  logic            legal;
  logic [IDX_W-1:0] idx;

  logic err_p1;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  initial begin
    for (int w = 0; w < DEPTH_WORDS; w++) mem[w] = '0;
  end

  assign o_ready  = (state == IDLE);
  assign o_rvalid = (state == RESPOND);
  assign o_err    = err_p1 && o_rvalid;
  assign accept   = i_valid && o_ready;

  // In IDLE the only request that can enter RESPOND directly is the one on the
  // inputs (LATENCY==1); everywhere else the latched copy is authoritative.
  always_comb begin
    src_addr = (state == IDLE) ? i_addr : req_addr_p0;
    src_rw   = (state == IDLE) ? i_rw   : req_rw_p0;
    offset   = {1'b0, src_addr} - {1'b0, BASE_ADDR};
    in_range = (src_addr >= BASE_ADDR) && (offset < SPAN);
    aligned  = (src_addr[1:0] == 2'b00);
    legal    = in_range && aligned;
    idx      = offset[IDX_W+1:2];
  end

  // Next-state logic: IDLE -> (WAIT ->) RESPOND -> IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? RESPOND : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESPOND;
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_respond = (state_nxt == RESPOND) && (state != RESPOND);
  assign commit        = (state == RESPOND) && req_rw_p0 && legal && !i_reset;

  // State, latency counter and accept counter; reset drops any pending request
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      o_req_count <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) o_req_count <= o_req_count + 16'd1;
    end
  end

  // ---- stage p0: capture the request so later input changes are ignored ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      req_addr_p0  <= i_addr;
      req_rw_p0    <= i_rw;
      req_wdata_p0 <= i_wdata;
      req_wmask_p0 <= i_wmask;
    end
  end

  // ---- stage p1: response data/error registered on entry to RESPOND ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rdata <= '0;
      err_p1  <= 1'b0;
    end else if (enter_respond) begin
      err_p1 <= !legal;
      if (src_rw)     o_rdata <= '0;
      else if (legal) o_rdata <= mem[idx];
      else            o_rdata <= FILL_WORD;
    end
  end

  // Byte-lane write commit at the end of the RESPOND cycle
  always_ff @(posedge i_clk) begin
    if (commit) begin
      for (int b = 0; b < LANES; b++) begin
        if (req_wmask_p0[b]) mem[idx][8*b +: 8] <= req_wdata_p0[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder: a LATENCY=2 instance with default
// geometry and a small LATENCY=1 instance, sharing clock and reset.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, rw_s;
  logic [31:0] addr_s, wdata_s;
  logic [3:0]  wmask_s;
  logic        ready, rvalid, err;
  logic [31:0] rdata;
  logic [15:0] req_count;

  logic        b_valid, b_rw;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wmask;
  logic        b_ready, b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic [15:0] b_req_count;

  int checks = 0;
  int passes = 0;

  logic [31:0] r_data;
  logic        r_err, r_after;
  int          r_lat;

  always #5 clk = ~clk;

  imem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2),
                   .INIT_FILE(""), .FILL_WORD(32'h0000_0013)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_addr(addr_s), .i_rw(rw_s),
    .i_wdata(wdata_s), .i_wmask(wmask_s), .o_ready(ready), .o_rdata(rdata),
    .o_rvalid(rvalid), .o_err(err), .o_req_count(req_count));

  imem_responder #(.XLEN(32), .DEPTH_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(1),
                   .INIT_FILE(""), .FILL_WORD(32'h0000_0013)) dut_l1 (
    .i_clk(clk), .i_reset(rst), .i_valid(b_valid), .i_addr(b_addr), .i_rw(b_rw),
    .i_wdata(b_wdata), .i_wmask(b_wmask), .o_ready(b_ready), .o_rdata(b_rdata),
    .o_rvalid(b_rvalid), .o_err(b_err), .o_req_count(b_req_count));

  // Issue one request on the LATENCY=2 instance and capture its response.
  // r_lat = cycles after the accept edge until rvalid (99 if never accepted).
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int  n;
    logic acc;
    valid = 1'b1; rw_s = w; addr_s = a; wdata_s = d; wmask_s = m;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      acc = ready;
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b0; addr_s = 32'h0; wdata_s = 32'h0; wmask_s = 4'h0;
    r_lat = 0;
    if (!acc) r_lat = 99;
    else while (!rvalid && r_lat < 20) begin
      @(posedge clk); #1;
      r_lat++;
    end
    r_data = rdata; r_err = err;
    @(posedge clk); #1;
    r_after = rvalid;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; rw_s = 1'b0; addr_s = '0; wdata_s = '0; wmask_s = '0;
    b_valid = 1'b0; b_rw = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passes++;
    checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata); else passes++;
    checks++; if (req_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", req_count); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_read_path();
    req(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
    checks++; if (r_lat !== 1) $display("FAIL wr0_latency: got %0d want 1", r_lat); else passes++;
    checks++; if (r_data !== 32'h0) $display("FAIL wr0_rdata: got %h want 00000000", r_data); else passes++;
    checks++; if (r_after !== 1'b0) $display("FAIL wr0_pulse_width: got %b want 0", r_after); else passes++;
    req(1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (r_lat !== 1) $display("FAIL rd0_latency: got %0d want 1", r_lat); else passes++;
    checks++; if (r_data !== 32'hDEADBEEF) $display("FAIL rd0_rdata: got %h want deadbeef", r_data); else passes++;
    checks++; if (r_err !== 1'b0) $display("FAIL rd0_err: got %b want 0", r_err); else passes++;
    checks++; if (r_after !== 1'b0) $display("FAIL rd0_pulse_width: got %b want 0", r_after); else passes++;
    checks++; if (req_count !== 16'd2) $display("FAIL rd0_count: got %0d want 2", req_count); else passes++;
  endtask

  task automatic test_masked_write();
    req(1'b1, 32'h10, 32'hAABBCCDD, 4'hF);
    req(1'b1, 32'h10, 32'h11223344, 4'b0011);
    checks++; if (r_data !== 32'h0) $display("FAIL mw_rdata: got %h want 00000000", r_data); else passes++;
    checks++; if (r_err !== 1'b0) $display("FAIL mw_err: got %b want 0", r_err); else passes++;
    req(1'b0, 32'h10, 32'h0, 4'h0);
    checks++; if (r_data !== 32'hAABB3344) $display("FAIL mw_readback: got %h want aabb3344", r_data); else passes++;
  endtask

  task automatic test_illegal();
    req(1'b0, 32'h1000, 32'h0, 4'h0);
    checks++; if (r_data !== 32'h00000013) $display("FAIL oor_rdata: got %h want 00000013", r_data); else passes++;
    checks++; if (r_err !== 1'b1) $display("FAIL oor_err: got %b want 1", r_err); else passes++;
    req(1'b0, 32'h2, 32'h0, 4'h0);
    checks++; if (r_data !== 32'h00000013) $display("FAIL mis_rd_rdata: got %h want 00000013", r_data); else passes++;
    checks++; if (r_err !== 1'b1) $display("FAIL mis_rd_err: got %b want 1", r_err); else passes++;
    req(1'b1, 32'h4, 32'h12345678, 4'hF);
    req(1'b1, 32'h6, 32'hFFFFFFFF, 4'hF);
    checks++; if (r_err !== 1'b1) $display("FAIL mis_wr_err: got %b want 1", r_err); else passes++;
    checks++; if (r_data !== 32'h0) $display("FAIL mis_wr_rdata: got %h want 00000000", r_data); else passes++;
    req(1'b0, 32'h4, 32'h0, 4'h0);
    checks++; if (r_data !== 32'h12345678) $display("FAIL mis_wr_ram_kept: got %h want 12345678", r_data); else passes++;
    checks++; if (r_err !== 1'b0) $display("FAIL rd4_err: got %b want 0", r_err); else passes++;
    req(1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF);
    req(1'b0, 32'hFFC, 32'h0, 4'h0);
    checks++; if (r_data !== 32'h5A5A5A5A) $display("FAIL last_word_rdata: got %h want 5a5a5a5a", r_data); else passes++;
    checks++; if (r_err !== 1'b0) $display("FAIL last_word_err: got %b want 0", r_err); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] rdy_v, rv_v;
    int accepts, post;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    valid = 1'b1; rw_s = 1'b0; addr_s = 32'h0;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      rdy_v[k] = ready;
      rv_v[k]  = rvalid;
      if (ready) accepts++;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    post = 0;
    for (int k = 0; k < 5; k++) begin
      if (rvalid) post++;
      @(posedge clk); #1;
    end
    checks++; if (rdy_v !== 10'b1001001001) $display("FAIL b2b_ready_pattern: got %b want 1001001001", rdy_v); else passes++;
    checks++; if (rv_v !== 10'b0100100100) $display("FAIL b2b_rvalid_pattern: got %b want 0100100100", rv_v); else passes++;
    checks++; if (accepts !== 4) $display("FAIL b2b_accepts: got %0d want 4", accepts); else passes++;
    checks++; if (post !== 1) $display("FAIL b2b_last_pulse: got %0d want 1", post); else passes++;
    checks++; if (req_count !== 16'd4) $display("FAIL b2b_count: got %0d want 4", req_count); else passes++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    req(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    valid = 1'b1; rw_s = 1'b1; addr_s = 32'h20; wdata_s = 32'hFFFFFFFF; wmask_s = 4'hF;
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (ready !== 1'b0) $display("FAIL rm_in_wait: got ready=%b want 0", ready); else passes++;
    rst = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (rvalid !== 1'b0) $display("FAIL rm_rvalid: got %b want 0", rvalid); else passes++;
    checks++; if (ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", ready); else passes++;
    checks++; if (req_count !== 16'd0) $display("FAIL rm_count: got %0d want 0", req_count); else passes++;
    @(posedge clk); #1;
    checks++; if (req_count !== 16'd0) $display("FAIL rm_valid_during_reset: got %0d want 0", req_count); else passes++;
    rst = 1'b0; valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rvalid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rm_no_response: got %b want 0", seen); else passes++;
    req(1'b0, 32'h20, 32'h0, 4'h0);
    checks++; if (r_data !== 32'h0BADF00D) $display("FAIL rm_old_value: got %h want 0badf00d", r_data); else passes++;
    checks++; if (req_count !== 16'd1) $display("FAIL rm_count_after: got %0d want 1", req_count); else passes++;
  endtask

  task automatic test_latency1();
    b_valid = 1'b1; b_rw = 1'b1; b_addr = 32'h8; b_wdata = 32'hCAFEBABE; b_wmask = 4'hF;
    checks++; if (b_ready !== 1'b1) $display("FAIL l1_ready_idle: got %b want 1", b_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b1) $display("FAIL l1_wr_rvalid: got %b want 1", b_rvalid); else passes++;
    checks++; if (b_ready !== 1'b0) $display("FAIL l1_ready_respond: got %b want 0", b_ready); else passes++;
    checks++; if (b_rdata !== 32'h0) $display("FAIL l1_wr_rdata: got %h want 00000000", b_rdata); else passes++;
    b_rw = 1'b0; b_wdata = 32'h0;
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b0) $display("FAIL l1_gap_rvalid: got %b want 0", b_rvalid); else passes++;
    checks++; if (b_ready !== 1'b1) $display("FAIL l1_gap_ready: got %b want 1", b_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b1) $display("FAIL l1_rd_rvalid: got %b want 1", b_rvalid); else passes++;
    checks++; if (b_rdata !== 32'hCAFEBABE) $display("FAIL l1_rd_rdata: got %h want cafebabe", b_rdata); else passes++;
    checks++; if (b_err !== 1'b0) $display("FAIL l1_rd_err: got %b want 0", b_err); else passes++;
    b_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b0) $display("FAIL l1_pulse_width: got %b want 0", b_rvalid); else passes++;
    checks++; if (b_req_count !== 16'd2) $display("FAIL l1_count: got %0d want 2", b_req_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_read_path();
    test_masked_write();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
